// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions N_CH raw, asynchronous push-button / switch inputs for the
// effect-control logic. Each channel is handled independently:
//   - a SYNC_STAGES-deep synchroniser brings the raw input into clk,
//   - a counter-based debouncer accepts a new value only after it has
//     persisted for DEBOUNCE_CYCLES consecutive cycles,
//   - a registered edge detector reports debounced transitions selected by
//     edge_mode (rising / falling / both / disabled),
//   - a hold counter issues a single long_press pulse once the debounced
//     level has stayed high for LONG_PRESS_CYCLES cycles.
//
// Ports:
//   clk          system clock (single clock domain)
//   reset        synchronous, active-high reset; clears every flop
//   button       [N_CH] raw asynchronous inputs, active-high
//   edge_mode    [2]    00 rising, 01 falling, 10 both, 11 disabled
//   level        [N_CH] debounced level per channel
//   button_edge  [N_CH] one-cycle pulse per qualifying debounced transition
//   long_press   [N_CH] one-cycle pulse per qualifying long hold
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_CH              = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int LONG_PRESS_CYCLES = 25000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] button,
    input  logic [1:0]      edge_mode,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] button_edge,
    output logic [N_CH-1:0] long_press
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    edge_mode_e mode;
    assign mode = edge_mode_e'(edge_mode);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_out;
        logic [DB_W-1:0]        db_cnt;
        logic [DB_W-1:0]        db_cnt_nxt;
        logic [HOLD_W-1:0]      hold_cnt;
        logic                   level_q;
        logic                   level_nxt;
        logic                   level_d;
        logic                   edge_q;
        logic                   edge_hit;
        logic                   long_q;

        assign sync_out = sync_q[SYNC_STAGES-1];

        // Debounce: any cycle where the synchronised value agrees with the
        // accepted level restarts the count, so glitches never accumulate.
        always_comb begin
            // NOTE: every output of a combinational block gets a default
            // first, so no path can leave it unassigned and infer a latch.
            level_nxt  = level_q;
            db_cnt_nxt = '0;
            if (sync_out != level_q) begin
                if (db_cnt == DB_LAST) begin
                    level_nxt = sync_out;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
        end

        // Edge qualification looks at the cycle in which the new level is
        // visible (level_q vs. its delayed copy), so a change of edge_mode
        // alone can never produce a pulse.
        always_comb begin
            edge_hit = 1'b0;
            case (mode)
                EDGE_RISE: edge_hit = level_q & ~level_d;
                EDGE_FALL: edge_hit = ~level_q & level_d;
                EDGE_BOTH: edge_hit = level_q ^ level_d;
                default:   edge_hit = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q   <= '0;
                db_cnt   <= '0;
                hold_cnt <= '0;
                level_q  <= 1'b0;
                level_d  <= 1'b0;
                edge_q   <= 1'b0;
                long_q   <= 1'b0;
            end else begin
                // NOTE: sequential state uses non-blocking assignments so
                // every flop samples the pre-edge values of the others.
                sync_q  <= {sync_q[SYNC_STAGES-2:0], button[ch]};
                db_cnt  <= db_cnt_nxt;
                level_q <= level_nxt;
                level_d <= level_q;
                edge_q  <= edge_hit;

                // The hold count only advances while the level is high now
                // and stays high across this edge; a release landing on the
                // edge that would hit the limit therefore suppresses the pulse.
                if (!level_q || !level_nxt) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end

                long_q <= level_q && level_nxt && (hold_cnt == HOLD_LAST);
            end
        end

        assign level[ch]       = level_q;
        assign button_edge[ch] = edge_q;
        assign long_press[ch]  = long_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner (N_CH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10). Every clock edge is driven through
// tick(), which advances a behavioural reference model and compares all three
// outputs against it. Directed scenarios add explicit timing/count checks;
// a randomized phase exercises bouncy inputs under each edge mode.
//
// Reference model (per channel, per non-reset edge k since reset):
//   - the value the debouncer sees is the button sampled at edge k-SYNC
//     (zero if that edge predates the reset),
//   - level flips once that value has disagreed with level on DEB
//     consecutive edges,
//   - an edge pulse follows one edge after a flip if the mode allows it,
//   - long_press fires on the edge where level has been high for LONG+1
//     consecutive edges (high after edge T .. high after edge T+LONG).
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   button;
    logic [1:0]     edge_mode;
    logic [N-1:0]   level;
    logic [N-1:0]   button_edge;
    logic [N-1:0]   long_press;

    button_conditioner #(
        .N_CH              (N),
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .edge_mode   (edge_mode),
        .level       (level),
        .button_edge (button_edge),
        .long_press  (long_press)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       ks;                 // non-reset edges since last reset edge
    bit       hist [N][64];       // button value sampled at edge k (ring)
    bit       m_level [N];
    int       dis_run [N];
    int       hi_run  [N];
    bit       pend_rise [N];
    bit       pend_fall [N];
    logic [N-1:0] exp_level, exp_edge, exp_long;

    task automatic model_step(input logic rst, input logic [N-1:0] btn, input logic [1:0] mode);
        bit seen;
        if (rst) begin
            ks = 0;
            for (int c = 0; c < N; c++) begin
                for (int j = 0; j < 64; j++) hist[c][j] = 1'b0;
                m_level[c]   = 1'b0;
                dis_run[c]   = 0;
                hi_run[c]    = 0;
                pend_rise[c] = 1'b0;
                pend_fall[c] = 1'b0;
            end
            exp_level = '0;
            exp_edge  = '0;
            exp_long  = '0;
            return;
        end
        for (int c = 0; c < N; c++) begin
            seen = (ks >= SYNC) ? hist[c][(ks - SYNC) % 64] : 1'b0;
            hist[c][ks % 64] = btn[c];

            exp_edge[c] = (pend_rise[c] && (mode == 2'd0 || mode == 2'd2)) ||
                          (pend_fall[c] && (mode == 2'd1 || mode == 2'd2));
            pend_rise[c] = 1'b0;
            pend_fall[c] = 1'b0;

            if (seen != m_level[c]) begin
                dis_run[c]++;
                if (dis_run[c] == DEB) begin
                    m_level[c]   = seen;
                    dis_run[c]   = 0;
                    pend_rise[c] = seen;
                    pend_fall[c] = !seen;
                end
            end else begin
                dis_run[c] = 0;
            end

            hi_run[c]    = m_level[c] ? hi_run[c] + 1 : 0;
            exp_long[c]  = (hi_run[c] == LONG + 1);
            exp_level[c] = m_level[c];
        end
        ks++;
    endtask

    // ---------------- observation helpers ----------------
    int n_edge [N];
    int n_long [N];
    int at_edge [N];   // edge index (since reset) of the last edge pulse
    int at_long [N];
    int at_rise [N];   // edge index of first observed level rise
    int max_lvl [N];

    task automatic clear_obs();
        for (int c = 0; c < N; c++) begin
            n_edge[c]  = 0;
            n_long[c]  = 0;
            at_edge[c] = -1;
            at_long[c] = -1;
            at_rise[c] = -1;
            max_lvl[c] = 0;
        end
    endtask

    logic [N-1:0] btn;
    logic [1:0]   mode;

    task automatic tick(input logic rst);
        int idx;
        reset     = rst;
        button    = btn;
        edge_mode = mode;
        @(posedge clk);
        model_step(rst, btn, mode);
        #1;
        check("level", 32'(level), 32'(exp_level));
        check("button_edge", 32'(button_edge), 32'(exp_edge));
        check("long_press", 32'(long_press), 32'(exp_long));
        idx = ks - 1;
        for (int c = 0; c < N; c++) begin
            if (button_edge[c]) begin n_edge[c]++; at_edge[c] = idx; end
            if (long_press[c])  begin n_long[c]++; at_long[c] = idx; end
            if (level[c] && at_rise[c] < 0) at_rise[c] = idx;
            if (level[c]) max_lvl[c] = 1;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0);
    endtask

    int base;
    int edge_cnt_exp [4] = '{1, 1, 2, 0};
    int rem [N];

    initial begin
        btn  = '0;
        mode = 2'b00;

        // ---- reset state ----
        tick(1'b1);
        tick(1'b1);
        check("reset_outputs", 32'({level, button_edge, long_press}), 32'h0);
        run(3);

        // ---- basic press/hold on channel 0, mode rising ----
        clear_obs();
        base   = ks;
        btn[0] = 1'b1;
        run(25);
        check("ch0_level_rise_edge", 32'(at_rise[0] - base), 32'd5);
        check("ch0_edge_at",         32'(at_edge[0] - base), 32'd6);
        check("ch0_edge_count",      32'(n_edge[0]), 32'd1);
        check("ch0_long_at",         32'(at_long[0] - base), 32'd15);
        check("ch0_long_count",      32'(n_long[0]), 32'd1);

        // ---- bounce rejection on channel 1 (mode both) ----
        mode = 2'b10;
        clear_obs();
        btn[1] = 1'b1; tick(1'b0);
        btn[1] = 1'b0; tick(1'b0);
        btn[1] = 1'b1; tick(1'b0);
        btn[1] = 1'b0; tick(1'b0);
        run(12);
        check("ch1_level_stayed_low", 32'(max_lvl[1]), 32'd0);
        check("ch1_no_edge", 32'(n_edge[1]), 32'd0);
        check("ch1_no_long", 32'(n_long[1]), 32'd0);

        // ---- mode coverage on channel 2 ----
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            run(2);
            clear_obs();
            btn[2] = 1'b1; run(7);
            btn[2] = 1'b0; run(12);
            check($sformatf("ch2_edges_mode%0d", m), 32'(n_edge[2]), 32'(edge_cnt_exp[m]));
            check($sformatf("ch2_level_seen_mode%0d", m), 32'(max_lvl[2]), 32'd1);
            check($sformatf("ch2_level_final_mode%0d", m), 32'(level[2]), 32'd0);
        end

        // ---- early release / later long hold on channel 3 ----
        mode = 2'b00;
        clear_obs();
        btn[3] = 1'b1; run(9);
        btn[3] = 1'b0; run(12);
        check("ch3_short_no_long", 32'(n_long[3]), 32'd0);
        clear_obs();
        btn[3] = 1'b1; run(12);
        btn[3] = 1'b0; run(12);
        check("ch3_long_once", 32'(n_long[3]), 32'd1);

        // ---- reset mid-operation on channel 0 ----
        btn[0] = 1'b0; run(12);
        clear_obs();
        base   = ks;
        btn[0] = 1'b1;
        run(11);   // level high after rel edge 5; hold count reaches 5 at rel edge 10
        check("ch0_pre_reset_level", 32'(level[0]), 32'd1);
        tick(1'b1);
        check("reset_mid_outputs", 32'({level, button_edge, long_press}), 32'h0);
        clear_obs();
        run(20);
        check("ch0_reacq_edge_at",  32'(at_edge[0]), 32'd6);
        check("ch0_reacq_long_at",  32'(at_long[0]), 32'd15);
        check("ch0_reacq_long_cnt", 32'(n_long[0]), 32'd1);

        // ---- all channels simultaneously ----
        btn = '0; run(12);
        clear_obs();
        base = ks;
        btn  = '1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            if (ks - 1 - base == 6)  check("all_edge", 32'(button_edge), 32'hF);
            if (ks - 1 - base == 15) check("all_long", 32'(long_press), 32'hF);
        end
        btn = '0; run(12);

        // ---- randomized bouncy traffic, one segment per mode ----
        for (int seg = 0; seg < 4; seg++) begin
            mode = 2'($urandom_range(0, 3));
            for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 16);
            for (int i = 0; i < 250; i++) begin
                for (int c = 0; c < N; c++) begin
                    rem[c]--;
                    if (rem[c] == 0) begin
                        btn[c] = ~btn[c];
                        rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                              : $urandom_range(4, 18);
                    end
                end
                tick(1'b0);
            end
            btn = '0;
            run(12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
